fp_norm_round_seq: RTL and testbench
====================================

// Module: fp_norm_round_seq
// PURPOSE
//  Back end of the FP32 add/sub datapath. Consumes the raw result of the mantissa add/sub
//  stage (sign, carry, 24b sum, 24b guard/round/sticky field) plus the common exponent.
//  Normalizes the sum, rounds it per RISC-V frm and packs an IEEE-754 binary32 result
//  with fflags. Multi-cycle, with a valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   8   biased exponent width
//  MAN_W   24  mantissa width including hidden bit (grs field is also MAN_W bits)
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  in_valid         in   1   input bundle valid
//  in_ready         out  1   block can accept a bundle (high only in IDLE)
//  sign_res         in   1   sign of the raw sum
//  carry            in   1   carry-out of the mantissa add
//  mantissa_sum     in   24  raw sum, MSB = hidden-bit position
//  grs              in   24  bits below the LSB; [23]=guard, |[22:0]=round/sticky
//  exp_in           in   8   biased exponent of the larger operand
//  rm               in   3   RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4; values 5-7 are handled as RNE
//  in_bypass        in   1   special case already resolved upstream (NaN/Inf/zero)
//  in_bypass_result in   32  result to forward when in_bypass=1
//  out_valid        out  1   result valid; held until out_ready
//  out_ready        in   1   consumer accepts the result
//  result           out  32  packed binary32 result
//  fflags           out  5   {NV,DZ,OF,UF,NX}; NV and DZ are always 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, fflags=0.
//  - FSM states: IDLE -> NORM -> ROUND -> DONE -> IDLE. Bypass path: IDLE -> DONE.
//  - IDLE: on in_valid&in_ready, register the bundle.
//    - carry=1: {carry,mant,grs}>>1, the bit shifted out is ORed into grs[0], and exp+1.
//    - in_bypass=1: result=in_bypass_result, fflags=0, go to DONE.
//  - Internal exponent: 10b signed, so overflow and underflow are detected without wrap.
//  - NORM: each cycle, if mant[23]=1, or exp<=1, or {mant,grs}==0, go to ROUND.
//    - Otherwise {mant,grs}<<=1 (mant[0]<=grs[23]) and exp-=1; one bit per cycle.
//    - If exp<=1 and mant[23]=0, the result is subnormal: exponent field = 0.
//  - ROUND: g=grs[23], rs=|grs[22:0], inexact=g|rs. Round up when:
//    - RNE: g&(rs|lsb); RTZ: never; RDN: sign&inexact; RUP: ~sign&inexact; RMM: g.
//    - Increment carry-out: mant=0x800000, exp+1. Subnormal rounding into bit 23: exp field 1.
//  - Overflow (exp>=255 after rounding): OF=NX=1.
//    - Inf for RNE/RMM, for RUP when sign=0, and for RDN when sign=1; else 0x7F7FFFFF|sign.
//  - UF = tiny after rounding (exp field 0) & inexact. NX = inexact | OF.
//  - Exact zero ({carry,mant,grs}==0, not bypass): result = {(rm==RDN),31'b0}, fflags=0.
//  - DONE: out_valid=1; result and fflags stay stable until out_ready. The handshake
//    cycle returns to IDLE; in_ready rises the next cycle. No input is accepted in
//    the same cycle as the output handshake.
//  - Latency: out_valid asserts 3+k cycles after the accept edge, where k = number of
//    left shifts. Bypass latency is 1 cycle.
// CONFIGURATION
//  FP_NORM_LZC_EN defined:
//    - NORM runs a single-cycle leading-zero count over {mant,grs}.
//    - Shift = min(lzc, exp-1); latency is a fixed 3 cycles.
//  FP_NORM_LZC_EN undefined:
//    - Iterative 1-bit/cycle shifter, latency 3+k.
//  result and fflags are bit-identical in both builds.
// TESTING
//  1. exp_in=0x7F, carry=0, sum=0x800000, grs=0, RNE -> result=0x3F800000, fflags=0,
//     out_valid at T+3.
//  2. exp_in=0x7F, carry=1, sum=0x000000, grs=0 -> 0x40000000, fflags=0.
//  3. exp_in=0x7F, sum=0x000001, grs=0 -> 0x34000000, out_valid at T+26
//     (T+3 with FP_NORM_LZC_EN).
//  4. exp_in=0x7F, sum=0x800001, grs=0x800000:
//     RNE -> 0x3F800002, fflags=0x01; RTZ -> 0x3F800001, fflags=0x01.
//  5. exp_in=0xFE, carry=1, sum=0xFFFFFF, sign=0:
//     RNE -> 0x7F800000, fflags=0x05; RTZ -> 0x7F7FFFFF, fflags=0x05.
//  6. Backpressure and reset:
//     - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
//     - Assert reset mid-NORM -> out_valid=0 immediately, in_ready=1.
//     - A new bundle after reset completes correctly.

Source files
------------

// File: rtl/fp_norm_round_seq.sv
// rtl/fp_norm_round_seq.sv - FP32 add/sub normalize, round and pack back end
//
// Purpose:
//    Takes the raw result of the mantissa add/sub stage and the common exponent.
//    Normalizes the sum and rounds it per RISC-V frm. Packs an IEEE-754 binary32
//    result together with fflags.
//    Sequencing is IDLE -> NORM -> ROUND -> DONE; a bypassed bundle goes IDLE -> DONE.
// Ports:
//    clk, reset               clock, asynchronous active-high reset
//    in_valid / in_ready      input handshake; in_ready is high only in IDLE
//    sign_res, carry          sign and carry-out of the raw sum
//    mantissa_sum             raw sum, MSB at the hidden-bit position
//    grs                      bits below the sum LSB ([MSB]=guard, rest round/sticky)
//    exp_in                   biased exponent of the larger operand
//    rm                       rounding mode (RNE/RTZ/RDN/RUP/RMM, 5-7 act as RNE)
//    in_bypass, in_bypass_result   pre-resolved special result, forwarded as is
//    out_valid / out_ready    output handshake; result/fflags held until accepted
//    result, fflags           packed binary32 and {NV,DZ,OF,UF,NX}
// Build option:
//    FP_NORM_LZC_EN           NORM uses a one-cycle leading-zero count. Without it,
//                             NORM shifts one bit per cycle. Results are identical.

module fp_norm_round_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   sign_res,
   input  logic                   carry,
   input  logic [MAN_W-1:0]       mantissa_sum,
   input  logic [MAN_W-1:0]       grs,
   input  logic [EXP_W-1:0]       exp_in,
   input  logic [2:0]             rm,
   input  logic                   in_bypass,
   input  logic [EXP_W+MAN_W-1:0] in_bypass_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W-1:0] result,
   output logic [4:0]             fflags
);

   localparam int IW = EXP_W + 2;        // signed internal exponent, no wrap
   localparam int FW = 2 * MAN_W;        // {mant, grs}
   localparam int RW = EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] EF_INF  = '1;
   localparam logic [EXP_W-1:0] EF_MAXN = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [IW-1:0]    EXP_ONE = IW'(1);
   localparam logic [IW-1:0]    EXP_MAX = {2'b00, EF_INF};
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

   state_t         state_q, state_d;
   logic           sign_q, sign_d;
   logic [2:0]     rm_q, rm_d;
   logic [FW-1:0]  frac_q, frac_d;
   logic [IW-1:0]  exp_q, exp_d;
   logic [RW-1:0]  result_q, result_d;
   logic [4:0]     fflags_q, fflags_d;

   logic             norm_stop;
   logic [MAN_W-1:0] mant;
   logic             guard, rsticky, inexact, lsb, round_up;
   logic [MAN_W:0]   mant_inc;
   logic [MAN_W-1:0] mant_r;
   logic [IW-1:0]    exp_r, field_r;
   logic             tiny, ovf, inf_sel;

   // Normalization stops at a set hidden bit or at the minimum exponent. Below
   // that minimum the value is subnormal and keeps the fixed exponent-1 scale.
   assign norm_stop = frac_q[FW-1] | ($signed(exp_q) <= $signed(EXP_ONE)) | (frac_q == '0);

`ifdef FP_NORM_LZC_EN
   localparam int LW = $clog2(FW + 1);
   logic [LW-1:0] lzc;
   logic [IW-1:0] shamt;

   always_comb begin
      lzc = LW'(FW);
      for (int i = 0; i < FW; i++) begin
         if (frac_q[i]) lzc = LW'(FW - 1 - i);
      end
      // Only meaningful when norm_stop is low, i.e. exp_q > 1.
      if ({{(IW-LW){1'b0}}, lzc} < (exp_q - EXP_ONE)) shamt = {{(IW-LW){1'b0}}, lzc};
      else                                            shamt = exp_q - EXP_ONE;
   end
`endif

   // Rounding datapath, consumed in ROUND
   always_comb begin
      mant    = frac_q[FW-1:MAN_W];
      guard   = frac_q[MAN_W-1];
      rsticky = |frac_q[MAN_W-2:0];
      inexact = guard | rsticky;
      lsb     = mant[0];
      case (rm_q)
         RM_RTZ:  round_up = 1'b0;
         RM_RDN:  round_up = sign_q & inexact;
         RM_RUP:  round_up = ~sign_q & inexact;
         RM_RMM:  round_up = guard;
         default: round_up = guard & (rsticky | lsb);
      endcase
      mant_inc = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
      if (mant_inc[MAN_W]) begin
         mant_r = {1'b1, {(MAN_W-1){1'b0}}};
         exp_r  = exp_q + EXP_ONE;
      end else begin
         mant_r = mant_inc[MAN_W-1:0];
         exp_r  = exp_q;
      end
      // A subnormal that rounds into the hidden bit picks up exponent field 1 here.
      field_r = mant_r[MAN_W-1] ? exp_r : '0;
      tiny    = (field_r == '0);
      ovf     = ($signed(field_r) >= $signed(EXP_MAX));
      case (rm_q)
         RM_RTZ:  inf_sel = 1'b0;
         RM_RDN:  inf_sel = sign_q;
         RM_RUP:  inf_sel = ~sign_q;
         default: inf_sel = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      rm_d     = rm_q;
      frac_d   = frac_q;
      exp_d    = exp_q;
      result_d = result_q;
      fflags_d = fflags_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d = sign_res;
               rm_d   = rm;
               if (in_bypass) begin
                  result_d = in_bypass_result;
                  fflags_d = '0;
                  state_d  = S_DONE;
               end else begin
                  if (carry) begin
                     // Right shift by one; the dropped bit folds into sticky.
                     frac_d = {1'b1, mantissa_sum, grs[MAN_W-1:2], grs[1] | grs[0]};
                     exp_d  = {2'b00, exp_in} + EXP_ONE;
                  end else begin
                     frac_d = {mantissa_sum, grs};
                     exp_d  = {2'b00, exp_in};
                  end
                  state_d = S_NORM;
               end
            end
         end
         S_NORM: begin
`ifdef FP_NORM_LZC_EN
            if (!norm_stop) begin
               frac_d = frac_q << shamt;
               exp_d  = exp_q - shamt;
            end
            state_d = S_ROUND;
`else
            if (norm_stop) begin
               state_d = S_ROUND;
            end else begin
               frac_d = frac_q << 1;
               exp_d  = exp_q - EXP_ONE;
            end
`endif
         end
         S_ROUND: begin
            if (frac_q == '0) begin
               result_d = {(rm_q == RM_RDN), {(RW-1){1'b0}}};
               fflags_d = '0;
            end else if (ovf) begin
               result_d = inf_sel ? {sign_q, EF_INF, {(MAN_W-1){1'b0}}}
                                  : {sign_q, EF_MAXN, {(MAN_W-1){1'b1}}};
               fflags_d = 5'b00101;
            end else begin
               result_d = {sign_q, field_r[EXP_W-1:0], mant_r[MAN_W-2:0]};
               fflags_d = {3'b000, tiny & inexact, inexact};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         rm_q     <= '0;
         frac_q   <= '0;
         exp_q    <= '0;
         result_q <= '0;
         fflags_q <= '0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         rm_q     <= rm_d;
         frac_q   <= frac_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         fflags_q <= fflags_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign fflags    = fflags_q;

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// tb/tb_fp_norm_round_seq.sv - self-checking bench for fp_norm_round_seq

module tb_fp_norm_round_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        sign_res;
   logic        carry;
   logic [23:0] mantissa_sum;
   logic [23:0] grs;
   logic [7:0]  exp_in;
   logic [2:0]  rm;
   logic        in_bypass;
   logic [31:0] in_bypass_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  fflags;

   int n_cmp = 0;
   int n_err = 0;

   fp_norm_round_seq #(.EXP_W(8), .MAN_W(24)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .sign_res         (sign_res),
      .carry            (carry),
      .mantissa_sum     (mantissa_sum),
      .grs              (grs),
      .exp_in           (exp_in),
      .rm               (rm),
      .in_bypass        (in_bypass),
      .in_bypass_result (in_bypass_result),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .result           (result),
      .fflags           (fflags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Value-level reference: the bundle is the exact number N * 2^(exp_in-174)
   // with N = {carry,sum,grs}. Round it to binary32 by integer division.
   function automatic void model(input logic c, input logic [23:0] s, input logic [23:0] g,
                                 input logic [7:0] e, input logic [2:0] r, input logic sg,
                                 output logic [31:0] res, output logic [4:0] fl, output int lat);
      longint unsigned n, m, rem, half;
      int p, lsb, be, ei;
      logic [2:0] rr;
      logic up, inexact, inf;
      ei  = int'(e);
      n   = 64'({c, s, g});
      rr  = (r > 3'd4) ? 3'd0 : r;
      lat = 3;
      if (n == 64'd0) begin
         res = {(r == 3'd2), 31'b0};
         fl  = 5'b0;
         return;
      end
      p = 48;
      while (((n >> p) & 64'd1) == 64'd0) p--;
      lsb = (p - 23 > 25 - ei) ? p - 23 : 25 - ei;
`ifndef FP_NORM_LZC_EN
      if (!c) lat = 3 + ((47 - p < ei - 1) ? 47 - p : ei - 1);
`endif
      if (lsb > 0) begin
         m    = n >> lsb;
         rem  = n & ((64'd1 << lsb) - 64'd1);
         half = 64'd1 << (lsb - 1);
      end else begin
         m    = n << (-lsb);
         rem  = 64'd0;
         half = 64'd1;
      end
      inexact = (rem != 64'd0);
      case (rr)
         3'd1:    up = 1'b0;
         3'd2:    up = sg && inexact;
         3'd3:    up = !sg && inexact;
         3'd4:    up = (rem >= half);
         default: up = (rem > half) || ((rem == half) && m[0]);
      endcase
      if (up) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
         m = 64'd1 << 23;
         lsb++;
      end
      be = (m >= (64'd1 << 23)) ? lsb + ei - 24 : 0;
      if (be >= 255) begin
         inf = (rr == 3'd0) || (rr == 3'd4) || (rr == 3'd3 && !sg) || (rr == 3'd2 && sg);
         res = inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7FFFFF};
         fl  = 5'b00101;
      end else begin
         res = {sg, be[7:0], m[22:0]};
         fl  = {3'b000, (be == 0) && inexact, inexact};
      end
   endfunction

   task automatic run_vec(input string tag, input logic c, input logic [23:0] s,
                          input logic [23:0] g, input logic [7:0] e, input logic [2:0] r,
                          input logic sg, input logic byp, input logic [31:0] bres,
                          input int hold, output logic [31:0] o_res, output logic [4:0] o_fl);
      logic [31:0] exp_res;
      logic [4:0]  exp_fl;
      int          exp_lat;
      int          n;
      logic        got;
      if (byp) begin
         exp_res = bres;
         exp_fl  = 5'b0;
         exp_lat = 1;
      end else begin
         model(c, s, g, e, r, sg, exp_res, exp_fl, exp_lat);
      end
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
      carry = c; mantissa_sum = s; grs = g; exp_in = e; rm = r; sign_res = sg;
      in_bypass = byp; in_bypass_result = bres; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         got = out_valid;
      end
      check({tag, "/latency"}, 64'(n), 64'(exp_lat));
      check({tag, "/result"}, 64'(result), 64'(exp_res));
      check({tag, "/fflags"}, 64'(fflags), 64'(exp_fl));
      o_res = result;
      o_fl  = fflags;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
         check({tag, "/hold_result"}, 64'(result), 64'(exp_res));
         check({tag, "/hold_fflags"}, 64'(fflags), 64'(exp_fl));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, "/post_valid"}, 64'(out_valid), 64'd0);
      check({tag, "/post_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      logic [4:0]  f;
      logic [23:0] s, g;
      logic [7:0]  e;
      logic        c, byp;
      int          sh, sel;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sign_res = 1'b0; carry = 1'b0;
      mantissa_sum = '0; grs = '0; exp_in = '0; rm = '0; in_bypass = 1'b0;
      in_bypass_result = '0;
      repeat (2) @(negedge clk);
      check("reset/in_ready", 64'(in_ready), 64'd1);
      check("reset/out_valid", 64'(out_valid), 64'd0);
      check("reset/result", 64'(result), 64'd0);
      check("reset/fflags", 64'(fflags), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_vec("t1", 1'b0, 24'h800000, 24'h0, 8'h7F, 3'd0, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t1/spec_res", 64'(r), 64'h3F800000);
      check("t1/spec_fl", 64'(f), 64'h0);
      run_vec("t2", 1'b1, 24'h000000, 24'h0, 8'h7F, 3'd0, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t2/spec_res", 64'(r), 64'h40000000);
      run_vec("t3", 1'b0, 24'h000001, 24'h0, 8'h7F, 3'd0, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t3/spec_res", 64'(r), 64'h34000000);
      run_vec("t4rne", 1'b0, 24'h800001, 24'h800000, 8'h7F, 3'd0, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t4rne/spec_res", 64'(r), 64'h3F800002);
      check("t4rne/spec_fl", 64'(f), 64'h01);
      run_vec("t4rtz", 1'b0, 24'h800001, 24'h800000, 8'h7F, 3'd1, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t4rtz/spec_res", 64'(r), 64'h3F800001);
      check("t4rtz/spec_fl", 64'(f), 64'h01);
      run_vec("t5rne", 1'b1, 24'hFFFFFF, 24'h0, 8'hFE, 3'd0, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t5rne/spec_res", 64'(r), 64'h7F800000);
      check("t5rne/spec_fl", 64'(f), 64'h05);
      run_vec("t5rtz", 1'b1, 24'hFFFFFF, 24'h0, 8'hFE, 3'd1, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("t5rtz/spec_res", 64'(r), 64'h7F7FFFFF);
      check("t5rtz/spec_fl", 64'(f), 64'h05);
      run_vec("zero_rdn", 1'b0, 24'h0, 24'h0, 8'h40, 3'd2, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("zero_rdn/spec_res", 64'(r), 64'h80000000);
      run_vec("subn", 1'b0, 24'h000003, 24'hC00000, 8'h01, 3'd0, 1'b1, 1'b0, 32'h0, 0, r, f);
      check("subn/spec_res", 64'(r), 64'h80000004);
      check("subn/spec_fl", 64'(f), 64'h03);
      run_vec("bypass", 1'b0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b1, 32'h7FC00000, 0, r, f);
      check("bypass/spec_res", 64'(r), 64'h7FC00000);
      run_vec("backpressure", 1'b0, 24'h800001, 24'h800000, 8'h7F, 3'd0, 1'b0, 1'b0, 32'h0, 5, r, f);

      // Reset in the middle of a long normalization
      carry = 1'b0; mantissa_sum = 24'h000001; grs = '0; exp_in = 8'h7F; rm = 3'd0;
      sign_res = 1'b0; in_bypass = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid/busy_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      #1;
      check("rst_mid/out_valid", 64'(out_valid), 64'd0);
      check("rst_mid/in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_vec("after_rst", 1'b0, 24'h800000, 24'h0, 8'h7F, 3'd0, 1'b0, 1'b0, 32'h0, 0, r, f);
      check("after_rst/spec_res", 64'(r), 64'h3F800000);

      for (int k = 0; k < 300; k++) begin
         sel = int'($urandom_range(0, 15));
         c   = ($urandom_range(0, 3) == 0);
         sh  = int'($urandom_range(0, 24));
         s   = 24'($urandom);
         s   = s >> sh;
         g   = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         e   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 255));
         byp = (sel == 0);
         if (sel == 1) begin
            c = 1'b0; s = '0; g = '0;
         end
         run_vec("rand", c, s, g, e, 3'($urandom_range(0, 7)), 1'($urandom), byp,
                 $urandom, int'($urandom_range(0, 2)), r, f);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
